// File: rtl/stopwatch_timer.sv
// Stopwatch/timer core: run/pause/clear FSM, tick prescaler, up/down count with
// preload and countdown expiry, plus a show-ahead lap FIFO with valid/ready read.
module stopwatch_timer #(
  parameter int TICK_DIV  = 1000000,
  parameter int CNT_W     = 32,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             lap,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             lap_valid,
  output logic [CNT_W-1:0] lap_data,
  input  logic             lap_ready,
  output logic             lap_ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int FW = $clog2(LAP_DEPTH + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] PTR_MAX   = AW'(LAP_DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(LAP_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic             dir_reg, dir_next;

  logic [CNT_W-1:0] lap_mem [LAP_DEPTH];
  logic [AW-1:0]    rd_reg, rd_next;
  logic [AW-1:0]    wr_reg, wr_next;
  logic [FW-1:0]    fill_reg, fill_next;
  logic             ovf_reg, ovf_next;

  logic             tick;
  logic             load_ok;
  logic             expire;
  logic [CNT_W-1:0] count_dec;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;

  assign tick      = (state_reg == RUN) && (presc_reg == PRESC_MAX);
  assign load_ok   = load_en && !clear && ((state_reg == IDLE) || (state_reg == PAUSE));
  assign count_dec = count_reg - CNT_W'(1);
  assign expire    = tick && dir_reg && (count_dec == '0);

  // Control FSM: clear beats everything; expiry beats a pause in the same tick cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!clear && !pause && start)
          state_next = (dir && (count_reg == '0)) ? DONE : RUN;
      end
      RUN: begin
        if (clear)       state_next = IDLE;
        else if (expire) state_next = DONE;
        else if (pause)  state_next = PAUSE;
      end
      PAUSE: begin
        if (clear)                state_next = IDLE;
        else if (!pause && start) state_next = RUN;
      end
      DONE: begin
        if (clear) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dir_next = dir_reg;
    if ((state_reg == IDLE) && (state_next != IDLE))
      dir_next = dir;
  end

  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (load_ok)
      count_next = load_val;
    else if (tick)
      count_next = dir_reg ? count_dec : (count_reg + CNT_W'(1));
  end

  // Prescaler keeps its partial interval across PAUSE, restarts from 0 otherwise.
  always_comb begin
    presc_next = '0;
    if (clear || load_ok)
      presc_next = '0;
    else if (state_reg == RUN)
      presc_next = tick ? '0 : (presc_reg + PW'(1));
    else if (state_reg == PAUSE)
      presc_next = presc_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      presc_reg <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      presc_reg <= presc_next;
      dir_reg   <= dir_next;
    end
  end

  assign lap_valid = (fill_reg != '0);
  assign full      = (fill_reg == FILL_MAX);
  assign pop       = lap_valid && lap_ready && !clear;
  assign push_req  = lap && !clear && ((state_reg == RUN) || (state_reg == PAUSE));
  // A full FIFO still accepts a lap when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);

  always_comb begin
    rd_next   = rd_reg;
    wr_next   = wr_reg;
    fill_next = fill_reg;
    ovf_next  = ovf_reg;
    if (clear) begin
      rd_next   = '0;
      wr_next   = '0;
      fill_next = '0;
      ovf_next  = 1'b0;
    end else begin
      if (push)
        wr_next = (wr_reg == PTR_MAX) ? '0 : (wr_reg + AW'(1));
      if (pop)
        rd_next = (rd_reg == PTR_MAX) ? '0 : (rd_reg + AW'(1));
      if (push && !pop)
        fill_next = fill_reg + FW'(1);
      else if (pop && !push)
        fill_next = fill_reg - FW'(1);
      if (push_req && full && !pop)
        ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg   <= '0;
      wr_reg   <= '0;
      fill_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      rd_reg   <= rd_next;
      wr_reg   <= wr_next;
      fill_reg <= fill_next;
      ovf_reg  <= ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      lap_mem[wr_reg] <= count_reg;
  end

  assign lap_data = lap_valid ? lap_mem[rd_reg] : '0;
  assign lap_ovf  = ovf_reg;
  assign count    = count_reg;
  assign running  = (state_reg == RUN);
  assign paused   = (state_reg == PAUSE);
  assign expired  = (state_reg == DONE);

endmodule
